// File: rtl/centroid_tracker_if.sv
// centroid_tracker_if
//   Bundles the per-frame measurement input and the track output of a
//   centroid_tracker. The measurement source (centroid_detector side) is the
//   master; the tracker is the slave.
//   meas_strobe  1-cycle pulse, meas_* hold a new frame result
//   meas_x/y     10-bit centroid position
//   meas_valid   measurement holds a real blob
//   track_x/y    smoothed position (0 outside TRACK/COAST)
//   track_valid  high in TRACK or COAST
//   track_state  0 IDLE, 1 ACQUIRE, 2 TRACK, 3 COAST
//   track_lost   1-cycle pulse on COAST->IDLE
//   vel_x/y      signed per-frame delta of track_x/y
interface centroid_tracker_if;
  logic        meas_strobe;
  logic [9:0]  meas_x;
  logic [9:0]  meas_y;
  logic        meas_valid;
  logic [9:0]  track_x;
  logic [9:0]  track_y;
  logic        track_valid;
  logic [1:0]  track_state;
  logic        track_lost;
  logic [10:0] vel_x;
  logic [10:0] vel_y;

  modport master (
    output meas_strobe, meas_x, meas_y, meas_valid,
    input  track_x, track_y, track_valid, track_state, track_lost, vel_x, vel_y
  );

  modport slave (
    input  meas_strobe, meas_x, meas_y, meas_valid,
    output track_x, track_y, track_valid, track_state, track_lost, vel_x, vel_y
  );
endinterface

// File: rtl/centroid_tracker.sv
// centroid_tracker
//   Consumes one centroid measurement per frame and produces a smoothed,
//   outlier-filtered, persistence-checked object position. Holds the last
//   position through brief dropouts (COAST), then declares the track lost.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no object; waiting for a valid measurement
//   ACQUIRE | counting consecutive valid measurements
//   TRACK   | locked; EMA-smoothing each in-gate measurement
//   COAST   | locked but missing; position held, counting misses
//
// Ports
//   clk, rst_n   system clock, synchronous active-low reset
//   enable       low: strobes ignored, all state held
//   bus          centroid_tracker_if.slave (measurement in, track out)
//
// Optional feature
//   CENTROID_TRACKER_VELOCITY_EN  defined: vel_x/vel_y report the per-update
//   change of track_x/track_y. Undefined: vel_x/vel_y are tied to 0.
module centroid_tracker #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int ALPHA_SHIFT  = 2,
  parameter int ACQ_FRAMES   = 3,
  parameter int COAST_FRAMES = 8,
  parameter int MAX_JUMP     = 96
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  centroid_tracker_if.slave  bus
);

  localparam logic [9:0]  X_MAX = 10'(FRAME_WIDTH - 1);
  localparam logic [9:0]  Y_MAX = 10'(FRAME_HEIGHT - 1);
  localparam logic [10:0] JUMP  = 11'(MAX_JUMP);
  localparam logic [4:0]  ACQ_N = 5'(ACQ_FRAMES);
  localparam logic [8:0]  COAST_N = 9'(COAST_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2,
    S_COAST   = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [13:0] acc_x, acc_y, acc_x_nxt, acc_y_nxt;
  logic [3:0]  acq_cnt, acq_cnt_nxt;
  logic [7:0]  miss_cnt, miss_cnt_nxt;
  logic        lost_q, lost_nxt;
  logic        ema_upd;

  // Q10.4 accumulator -> rounded integer position, saturated to the frame edge.
  function automatic logic [9:0] round_sat(input logic [13:0] acc, input logic [9:0] max);
    logic [10:0] r;
    r = 11'(({1'b0, acc} + 15'd8) >> 4);
    if (r > {1'b0, max}) return max;
    return r[9:0];
  endfunction

  logic              strobe_evt;
  logic [9:0]        meas_cx, meas_cy;
  logic [9:0]        pos_x, pos_y;
  logic signed [10:0] dx, dy;
  logic [10:0]       adx, ady;
  logic              in_gate, hit, locked;
  logic signed [14:0] diff_x, diff_y, step_x, step_y;
  logic [13:0]       ema_x, ema_y, snap_x, snap_y;

  assign strobe_evt = bus.meas_strobe && enable;
  assign meas_cx    = (bus.meas_x > X_MAX) ? X_MAX : bus.meas_x;
  assign meas_cy    = (bus.meas_y > Y_MAX) ? Y_MAX : bus.meas_y;

  assign locked = (state == S_TRACK) || (state == S_COAST);
  assign pos_x  = locked ? round_sat(acc_x, X_MAX) : 10'd0;
  assign pos_y  = locked ? round_sat(acc_y, Y_MAX) : 10'd0;

  assign dx  = $signed({1'b0, meas_cx}) - $signed({1'b0, pos_x});
  assign dy  = $signed({1'b0, meas_cy}) - $signed({1'b0, pos_y});
  assign adx = dx[10] ? 11'(-dx) : 11'(dx);
  assign ady = dy[10] ? 11'(-dy) : 11'(dy);

  assign in_gate = (adx <= JUMP) && (ady <= JUMP);
  assign hit     = bus.meas_valid && (!locked || in_gate);

  // EMA step toward the new measurement; the step always moves acc toward
  // meas<<4, so the sum stays inside the 14-bit unsigned range.
  assign diff_x = $signed({1'b0, meas_cx, 4'b0000}) - $signed({1'b0, acc_x});
  assign diff_y = $signed({1'b0, meas_cy, 4'b0000}) - $signed({1'b0, acc_y});
  assign step_x = diff_x >>> ALPHA_SHIFT;
  assign step_y = diff_y >>> ALPHA_SHIFT;
  assign ema_x  = 14'($signed({1'b0, acc_x}) + step_x);
  assign ema_y  = 14'($signed({1'b0, acc_y}) + step_y);
  assign snap_x = {meas_cx, 4'b0000};
  assign snap_y = {meas_cy, 4'b0000};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc_x    <= '0;
      acc_y    <= '0;
      acq_cnt  <= '0;
      miss_cnt <= '0;
      lost_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc_x    <= acc_x_nxt;
      acc_y    <= acc_y_nxt;
      acq_cnt  <= acq_cnt_nxt;
      miss_cnt <= miss_cnt_nxt;
      lost_q   <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_x_nxt    = acc_x;
    acc_y_nxt    = acc_y;
    acq_cnt_nxt  = acq_cnt;
    miss_cnt_nxt = miss_cnt;
    lost_nxt     = 1'b0;
    ema_upd      = 1'b0;

    if (strobe_evt) begin
      unique case (state)
        S_IDLE: begin
          if (hit) begin
            if (ACQ_N <= 5'd1) begin
              state_nxt   = S_TRACK;
              acc_x_nxt   = snap_x;
              acc_y_nxt   = snap_y;
              acq_cnt_nxt = '0;
            end else begin
              state_nxt   = S_ACQUIRE;
              acq_cnt_nxt = 4'd1;
            end
          end
        end
        S_ACQUIRE: begin
          if (hit) begin
            if (({1'b0, acq_cnt} + 5'd1) >= ACQ_N) begin
              state_nxt   = S_TRACK;
              acc_x_nxt   = snap_x;
              acc_y_nxt   = snap_y;
              acq_cnt_nxt = '0;
            end else if (acq_cnt != 4'hf) begin
              acq_cnt_nxt = acq_cnt + 4'd1;
            end
          end else begin
            state_nxt   = S_IDLE;
            acq_cnt_nxt = '0;
          end
        end
        S_TRACK: begin
          if (hit) begin
            acc_x_nxt = ema_x;
            acc_y_nxt = ema_y;
            ema_upd   = 1'b1;
          end else begin
            state_nxt    = S_COAST;
            miss_cnt_nxt = 8'd1;
          end
        end
        S_COAST: begin
          if (hit) begin
            state_nxt    = S_TRACK;
            acc_x_nxt    = ema_x;
            acc_y_nxt    = ema_y;
            miss_cnt_nxt = '0;
            ema_upd      = 1'b1;
          end else if (({1'b0, miss_cnt} + 9'd1) >= COAST_N) begin
            state_nxt    = S_IDLE;
            acc_x_nxt    = '0;
            acc_y_nxt    = '0;
            miss_cnt_nxt = '0;
            lost_nxt     = 1'b1;
          end else if (miss_cnt != 8'hff) begin
            miss_cnt_nxt = miss_cnt + 8'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.track_x     = pos_x;
  assign bus.track_y     = pos_y;
  assign bus.track_valid = locked;
  assign bus.track_state = state;
  assign bus.track_lost  = lost_q;

`ifdef CENTROID_TRACKER_VELOCITY_EN
  logic [10:0] vel_x_q, vel_y_q;

  // Only an EMA update produces motion; snap entry and every other event
  // report zero velocity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vel_x_q <= '0;
      vel_y_q <= '0;
    end else if (strobe_evt) begin
      if (ema_upd) begin
        vel_x_q <= {1'b0, round_sat(acc_x_nxt, X_MAX)} - {1'b0, pos_x};
        vel_y_q <= {1'b0, round_sat(acc_y_nxt, Y_MAX)} - {1'b0, pos_y};
      end else begin
        vel_x_q <= '0;
        vel_y_q <= '0;
      end
    end
  end

  assign bus.vel_x = vel_x_q;
  assign bus.vel_y = vel_y_q;
`else
  assign bus.vel_x = '0;
  assign bus.vel_y = '0;
`endif

endmodule
